// File: rtl/trig_align_supervisor.sv
// trig_align_supervisor
//   Sequencer and health monitor for the 24-VFAT S-bit trigger alignment
//   datapath. It pulses the IDELAYCTRL reset and waits for RDY. It then pulses
//   the frame aligner reset and qualifies lock over the unmasked VFATs. While
//   locked it counts errored clocks and latches per-VFAT sticky flags.
//
//   Optional feature macro: TRIG_ALIGN_AUTO_REALIGN_EN. When it is defined, a
//   windowed error-rate threshold re-runs the alignment on its own.
//
// Ports
//   clock, reset_i          40 MHz clock, async active-high reset
//   sbit_mask[23:0]         1 = VFAT excluded from error evaluation
//   alignment_err[23:0]     per-VFAT frame alignment error (level)
//   sot_phase_err[23:0]     per-VFAT SOF phase error (level)
//   idly_rdy                IDELAYCTRL RDY (asynchronous)
//   realign_req, cnt_reset  single-clock control pulses
//   idelay_rst, aligner_rst reset pulses to the delay controller / aligners
//   locked, state[2:0]      status
//   err_cnt, realign_cnt, vfat_err_sticky, rdy_timeout  counters and flags
module trig_align_supervisor #(
    parameter int RST_CYCLES    = 32,
    parameter int LOCK_CYCLES   = 4096,
    parameter int RDY_TIMEOUT   = 65535,
    parameter int ERR_THRESH    = 16,
    parameter int WINDOW_CYCLES = 40000
) (
    input  logic        clock,
    input  logic        reset_i,
    input  logic [23:0] sbit_mask,
    input  logic [23:0] alignment_err,
    input  logic [23:0] sot_phase_err,
    input  logic        idly_rdy,
    input  logic        realign_req,
    input  logic        cnt_reset,
    output logic        idelay_rst,
    output logic        aligner_rst,
    output logic        locked,
    output logic [2:0]  state,
    output logic [15:0] err_cnt,
    output logic [7:0]  realign_cnt,
    output logic [23:0] vfat_err_sticky,
    output logic        rdy_timeout
);

    typedef enum logic [2:0] {
        RST_DLY  = 3'd0,
        WAIT_RDY = 3'd1,
        ALIGN    = 3'd2,
        SETTLE   = 3'd3,
        LOCKED   = 3'd4
    } state_t;

    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
    localparam logic [15:0] RDY_LAST = 16'(RDY_TIMEOUT - 1);
    localparam logic [15:0] LOCK_TGT = 16'(LOCK_CYCLES);

    // Out-of-range parameters are rejected at elaboration.
    if (RST_CYCLES < 1 || RST_CYCLES > 255 || LOCK_CYCLES < 1 || LOCK_CYCLES > 65535 ||
        RDY_TIMEOUT < 1 || RDY_TIMEOUT > 65535 || ERR_THRESH < 1 || ERR_THRESH > 65535 ||
        WINDOW_CYCLES < 1 || WINDOW_CYCLES > 65535) begin : g_bad_cfg
        $error("trig_align_supervisor: parameter out of range");
    end

    state_t      state_q, state_d;
    logic [15:0] tmr_q, tmr_d;
    logic        rdy_meta_q, rdy_meta_d, rdy_sync_q, rdy_sync_d;
    logic [23:0] aerr_q, aerr_d, serr_q, serr_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [7:0]  realign_cnt_q, realign_cnt_d;
    logic [23:0] sticky_q, sticky_d;
    logic        rdy_to_q, rdy_to_d;
    logic        aligned_once_q, aligned_once_d;
    logic        idelay_rst_q, idelay_rst_d;
    logic        aligner_rst_q, aligner_rst_d;
    logic        locked_q, locked_d;
    logic [23:0] verr;
    logic        any_err;
    logic [15:0] lock_nxt;
`ifdef TRIG_ALIGN_AUTO_REALIGN_EN
    localparam logic [15:0] THRESH   = 16'(ERR_THRESH);
    localparam logic [15:0] WIN_LAST = 16'(WINDOW_CYCLES - 1);
    logic [15:0] win_cnt_q, win_cnt_d, win_err_q, win_err_d;
`endif

    assign verr    = (aerr_q | serr_q) & ~sbit_mask;
    assign any_err = |verr;

    always_comb begin
        rdy_meta_d     = idly_rdy;
        rdy_sync_d     = rdy_meta_q;
        aerr_d         = alignment_err;
        serr_d         = sot_phase_err;
        state_d        = state_q;
        tmr_d          = tmr_q + 16'd1;
        err_cnt_d      = err_cnt_q;
        realign_cnt_d  = realign_cnt_q;
        sticky_d       = sticky_q;
        rdy_to_d       = rdy_to_q;
        aligned_once_d = aligned_once_q;
        lock_nxt       = any_err ? 16'd0 : tmr_q + 16'd1;

        case (state_q)
            RST_DLY: if (tmr_q == RST_LAST) state_d = WAIT_RDY;
            WAIT_RDY: begin
                // A sampled RDY only counts once it postdates the idelay_rst
                // release (output register + two sync stages = 3 clocks).
                if (rdy_sync_q && (tmr_q >= 16'd2 || tmr_q == RDY_LAST)) begin
                    state_d = ALIGN;
                end else if (tmr_q == RDY_LAST) begin
                    state_d  = RST_DLY;
                    rdy_to_d = 1'b1;
                end
            end
            ALIGN: if (tmr_q == RST_LAST) state_d = SETTLE;
            SETTLE: begin
                if (!rdy_sync_q)              state_d = RST_DLY;
                else if (realign_req)         state_d = ALIGN;
                else if (lock_nxt == LOCK_TGT) state_d = LOCKED;
                tmr_d = lock_nxt;
            end
            LOCKED: begin
                tmr_d = '0;
                if (!rdy_sync_q)      state_d = RST_DLY;
                else if (realign_req) state_d = ALIGN;
`ifdef TRIG_ALIGN_AUTO_REALIGN_EN
                else if (win_err_q >= THRESH) state_d = ALIGN;
`endif
            end
            default: state_d = RST_DLY;
        endcase

        // Every state starts its timer / lock counter from zero.
        if (state_d != state_q) tmr_d = '0;

        // The first ALIGN after reset is the initial bring-up, not a realign.
        if (state_d == ALIGN && state_q != ALIGN) begin
            if (aligned_once_q && realign_cnt_q != 8'hFF) realign_cnt_d = realign_cnt_q + 8'd1;
            aligned_once_d = 1'b1;
        end

        if (state_q == LOCKED) begin
            sticky_d = sticky_q | verr;
            if (any_err && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end

`ifdef TRIG_ALIGN_AUTO_REALIGN_EN
        win_cnt_d = '0;
        win_err_d = '0;
        if (state_q == LOCKED && state_d == LOCKED && win_cnt_q != WIN_LAST) begin
            win_cnt_d = win_cnt_q + 16'd1;
            win_err_d = win_err_q;
            if (any_err && win_err_q != 16'hFFFF) win_err_d = win_err_q + 16'd1;
        end
`endif

        if (cnt_reset) begin
            err_cnt_d     = '0;
            realign_cnt_d = '0;
            sticky_d      = '0;
            rdy_to_d      = 1'b0;
        end

        idelay_rst_d  = (state_d == RST_DLY);
        aligner_rst_d = (state_d == ALIGN);
        locked_d      = (state_d == LOCKED);
    end

    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= RST_DLY;
            tmr_q          <= '0;
            rdy_meta_q     <= 1'b0;
            rdy_sync_q     <= 1'b0;
            aerr_q         <= '0;
            serr_q         <= '0;
            err_cnt_q      <= '0;
            realign_cnt_q  <= '0;
            sticky_q       <= '0;
            rdy_to_q       <= 1'b0;
            aligned_once_q <= 1'b0;
            idelay_rst_q   <= 1'b1;
            aligner_rst_q  <= 1'b0;
            locked_q       <= 1'b0;
`ifdef TRIG_ALIGN_AUTO_REALIGN_EN
            win_cnt_q      <= '0;
            win_err_q      <= '0;
`endif
        end else begin
            state_q        <= state_d;
            tmr_q          <= tmr_d;
            rdy_meta_q     <= rdy_meta_d;
            rdy_sync_q     <= rdy_sync_d;
            aerr_q         <= aerr_d;
            serr_q         <= serr_d;
            err_cnt_q      <= err_cnt_d;
            realign_cnt_q  <= realign_cnt_d;
            sticky_q       <= sticky_d;
            rdy_to_q       <= rdy_to_d;
            aligned_once_q <= aligned_once_d;
            idelay_rst_q   <= idelay_rst_d;
            aligner_rst_q  <= aligner_rst_d;
            locked_q       <= locked_d;
`ifdef TRIG_ALIGN_AUTO_REALIGN_EN
            win_cnt_q      <= win_cnt_d;
            win_err_q      <= win_err_d;
`endif
        end
    end

    assign state           = state_q;
    assign idelay_rst      = idelay_rst_q;
    assign aligner_rst     = aligner_rst_q;
    assign locked          = locked_q;
    assign err_cnt         = err_cnt_q;
    assign realign_cnt     = realign_cnt_q;
    assign vfat_err_sticky = sticky_q;
    assign rdy_timeout     = rdy_to_q;

endmodule

// File: tb/tb_trig_align_supervisor.sv
// Self-checking bench for trig_align_supervisor (RST_CYCLES=4, LOCK_CYCLES=16,
// RDY_TIMEOUT=50, ERR_THRESH=3, WINDOW_CYCLES=100).
module tb_trig_align_supervisor;
    localparam int R = 4, L = 16, TO = 50, TH = 3, WIN = 100;

    logic        clock = 1'b0, reset_i = 1'b1;
    logic [23:0] sbit_mask = '0, alignment_err = '0, sot_phase_err = '0;
    logic        idly_rdy = 1'b1, realign_req = 1'b0, cnt_reset = 1'b0;
    logic        idelay_rst, aligner_rst, locked, rdy_timeout;
    logic [2:0]  state;
    logic [15:0] err_cnt;
    logic [7:0]  realign_cnt;
    logic [23:0] vfat_err_sticky;

    trig_align_supervisor #(
        .RST_CYCLES(R), .LOCK_CYCLES(L), .RDY_TIMEOUT(TO),
        .ERR_THRESH(TH), .WINDOW_CYCLES(WIN)
    ) dut (
        .clock(clock), .reset_i(reset_i), .sbit_mask(sbit_mask),
        .alignment_err(alignment_err), .sot_phase_err(sot_phase_err),
        .idly_rdy(idly_rdy), .realign_req(realign_req), .cnt_reset(cnt_reset),
        .idelay_rst(idelay_rst), .aligner_rst(aligner_rst), .locked(locked),
        .state(state), .err_cnt(err_cnt), .realign_cnt(realign_cnt),
        .vfat_err_sticky(vfat_err_sticky), .rdy_timeout(rdy_timeout)
    );

    always #5 clock = ~clock;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Reset is released 1 time unit after an edge; the next edge is edge 1.
    task automatic do_reset();
        reset_i = 1'b1;
        tick(2);
        reset_i = 1'b0;
    endtask

    task automatic wait_locked(input int max, input string nm);
        for (int i = 0; i < max && locked !== 1'b1; i++) tick(1);
        chk(nm, locked, 1);
    endtask

    task automatic pulse_cnt_reset();
        cnt_reset = 1'b1;
        tick(1);
        cnt_reset = 1'b0;
    endtask

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       idr;
        logic       alr;
        logic       lck;
    } vec_t;

    vec_t tbl[9];
    vec_t sbq[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   now;
        int   nhold;
        logic saw;
        vec_t e;

`ifdef TRIG_ALIGN_AUTO_REALIGN_EN
        nhold = 2;
`else
        nhold = 10;
`endif
        // Edge count after reset release -> expected {state, idelay_rst, aligner_rst, locked}.
        tbl[0] = '{0,  3'd0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{3,  3'd0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{4,  3'd1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{6,  3'd1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{7,  3'd2, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{10, 3'd2, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{11, 3'd3, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{26, 3'd3, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{27, 3'd4, 1'b0, 1'b0, 1'b1};

        // ---- Lock sequence, table driven through the scoreboard
        do_reset();
        chk("reset err_cnt", err_cnt, 0);
        chk("reset realign_cnt", realign_cnt, 0);
        chk("reset sticky", vfat_err_sticky, 0);
        chk("reset rdy_timeout", rdy_timeout, 0);
        now = 0;
        foreach (tbl[i]) begin
            sbq.push_back(tbl[i]);
            tick(tbl[i].cyc - now);
            now = tbl[i].cyc;
            e = sbq.pop_front();
            chk($sformatf("lock seq c%0d state", e.cyc), state, e.st);
            chk($sformatf("lock seq c%0d idelay_rst", e.cyc), idelay_rst, e.idr);
            chk($sformatf("lock seq c%0d aligner_rst", e.cyc), aligner_rst, e.alr);
            chk($sformatf("lock seq c%0d locked", e.cyc), locked, e.lck);
        end
        chk("lock seq realign_cnt", realign_cnt, 0);

        // ---- Masked error on VFAT 0 toggling through SETTLE and LOCKED
        sbit_mask = 24'h000001;
        do_reset();
        for (int i = 0; i < R + 3 + R + L; i++) begin
            alignment_err[0] = ~alignment_err[0];
            tick(1);
        end
        chk("masked locked", locked, 1);
        for (int i = 0; i < 6; i++) begin
            alignment_err[0] = ~alignment_err[0];
            tick(1);
        end
        alignment_err = '0;
        chk("masked err_cnt", err_cnt, 0);
        chk("masked sticky", vfat_err_sticky, 0);
        sot_phase_err[5] = 1'b1;
        tick(nhold);
        sot_phase_err = '0;
        tick(3);
        chk("sof err err_cnt", err_cnt, nhold);
        chk("sof err sticky", vfat_err_sticky, 24'h000020);
        chk("sof err still locked", locked, 1);
        sbit_mask = '0;

        // ---- Three errored clocks inside one window
        do_reset();
        wait_locked(100, "auto pre lock");
        tick(3);
        sot_phase_err[1] = 1'b1;
        tick(3);
        sot_phase_err = '0;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (aligner_rst === 1'b1) saw = 1'b1;
            tick(1);
        end
`ifdef TRIG_ALIGN_AUTO_REALIGN_EN
        chk("auto realign aligner_rst pulse", saw, 1);
        chk("auto realign realign_cnt", realign_cnt, 1);
`else
        chk("no auto realign aligner_rst", saw, 0);
        chk("no auto realign realign_cnt", realign_cnt, 0);
        chk("no auto realign locked", locked, 1);
`endif

        // ---- Two errored clocks in each of two consecutive windows
        wait_locked(100, "two win lock");
        pulse_cnt_reset();
        tick(5);
        sot_phase_err[2] = 1'b1;
        tick(2);
        sot_phase_err = '0;
        tick(102);
        sot_phase_err[2] = 1'b1;
        tick(2);
        sot_phase_err = '0;
        tick(10);
        chk("two win locked", locked, 1);
        chk("two win state", state, 3'd4);
        chk("two win realign_cnt", realign_cnt, 0);
        chk("two win err_cnt", err_cnt, 4);
        chk("two win sticky", vfat_err_sticky, 24'h000004);

        // ---- Ready loss from LOCKED, then timeout in WAIT_RDY
        idly_rdy = 1'b0;
        tick(2);
        chk("rdy loss +2 state", state, 3'd4);
        tick(1);
        chk("rdy loss +3 state", state, 3'd0);
        chk("rdy loss locked", locked, 0);
        chk("rdy loss idelay_rst", idelay_rst, 1);
        tick(R);
        chk("timeout wait state", state, 3'd1);
        tick(TO - 1);
        chk("timeout last wait state", state, 3'd1);
        chk("timeout flag before", rdy_timeout, 0);
        tick(1);
        chk("timeout back to RST_DLY", state, 3'd0);
        chk("timeout flag", rdy_timeout, 1);

        // ---- Recover; the ALIGN entry after a ready loss counts as a realign
        idly_rdy = 1'b1;
        pulse_cnt_reset();
        chk("cnt_reset rdy_timeout", rdy_timeout, 0);
        wait_locked(200, "relock");
        chk("relock realign_cnt", realign_cnt, 1);

        // ---- realign_req together with cnt_reset: clear wins
        realign_req = 1'b1;
        cnt_reset   = 1'b1;
        tick(1);
        realign_req = 1'b0;
        cnt_reset   = 1'b0;
        chk("req+clr state", state, 3'd2);
        chk("req+clr aligner_rst", aligner_rst, 1);
        chk("req+clr realign_cnt", realign_cnt, 0);
        chk("req+clr locked", locked, 0);

        // ---- Asynchronous reset in ALIGN
        tick(1);
        #2 reset_i = 1'b1;
        #1;
        chk("async rst aligner_rst", aligner_rst, 0);
        chk("async rst idelay_rst", idelay_rst, 1);
        chk("async rst state", state, 3'd0);
        tick(1);
        reset_i = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
